inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2: number of prefetch buffer entries, a power of two from 2 to 8.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port pc_in, input, 32 bits: the fetch address, driven by the CPU pc_out.
REQ-005 The block SHALL have port instruction, output, 32 bits: the instruction word delivered to the CPU.
REQ-006 The block SHALL have port inst_valid, output, 1 bit: instruction holds the word at pc_in this cycle.
REQ-007 The block SHALL have port misalign, output, 1 bit: pc_in[1:0] is non-zero.
REQ-008 The block SHALL have port mem_req, output, 1 bit: an instruction memory read request is pending.
REQ-009 The block SHALL have port mem_addr, output, 32 bits: the word address of the pending request.
REQ-010 The block SHALL have port mem_ack, input, 1 bit: the memory completes the request this cycle.
REQ-011 The block SHALL have port mem_rdata, input, 32 bits: the read data, valid only in a cycle with mem_ack=1.

Function
REQ-012 Buffer: DEPTH entries in FIFO order, each holding {addr, data, valid}; the head entry is the oldest.
REQ-013 Memory handshake: mem_req and mem_addr stay stable until mem_ack=1 is sampled; a request completes on the edge where mem_req=1 and mem_ack=1.
REQ-014 Handshake, cont.: mem_ack while mem_req=0 is ignored; a new request may start in the cycle after completion (back-to-back).
REQ-015 FSM states: IDLE (no request pending), BUSY (request pending, result kept), DROP (request pending, result discarded).
REQ-016 Hit, combinational: if a valid entry k has addr==pc_in, then instruction=data[k] and inst_valid=1.
REQ-017 Bypass: in BUSY, if mem_ack=1 and mem_addr==pc_in, then instruction=mem_rdata and inst_valid=1 in the same cycle; the word is also written into the buffer.
REQ-018 Otherwise inst_valid=0 and instruction=32'h00000013 (addi x0,x0,0).
REQ-019 Advance: on a hit at entry k>0, entries 0..k-1 are popped at the clock edge.
REQ-020 Pending: if no entry matches but the BUSY request has mem_addr==pc_in, nothing is flushed; the block waits.
REQ-021 Redirect (miss): all entries are invalidated at the edge.
REQ-022 Redirect, cont.: from IDLE, a request at pc_in starts on the next cycle; from BUSY, the FSM moves to DROP; from DROP, it stays in DROP.
REQ-023 DROP: on completion, the data is discarded and the next request, at the current pc_in, starts the following cycle.
REQ-024 Prefetch: when (valid entries + pending requests) < DEPTH, the FSM issues a request at next_addr = last buffered or requested addr + 4.
REQ-025 Prefetch addresses wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-026 Ordering and simultaneity: a fill and a pop in the same cycle are both applied; the buffer never exceeds DEPTH and never accepts a fill into a full buffer.
REQ-027 Misalignment: misalign=1 whenever pc_in[1:0]!=0; inst_valid is then 0, no new request is issued, a pending request completes normally, and the buffer is flushed.
REQ-028 Consumer contract: pc_in is held stable while inst_valid=0; inst_valid=0 acts as the CPU stall.

Reset
REQ-029 While reset=0, the block SHALL immediately force: FSM=IDLE, all entries invalid, mem_req=0, mem_addr=0, inst_valid=0, instruction=32'h00000013.
REQ-030 A request pending at reset assertion SHALL be abandoned; a later mem_ack in IDLE is ignored.
REQ-031 In the first cycle after reset deassertion, the block SHALL issue a request at pc_in.

Verification
REQ-032 Cold start: release reset with pc_in=0, memory latency 2 -> mem_req=1 with mem_addr=0; inst_valid=1 in the mem_ack cycle; next request at addr 4.
REQ-033 Sequential stream: zero-wait memory, pc_in increments by 4 every cycle from 0x100 -> after warm-up inst_valid=1 every cycle and the words match memory.
REQ-034 Redirect in flight: request for 0x108 pending, pc_in jumps to 0x400 -> state DROP, the 0x108 data is not delivered, next mem_addr=0x400, the buffer is empty before the fill.
REQ-035 Full buffer, DEPTH=2: pc_in held at 0x20 -> exactly 0x20 and 0x24 are buffered and mem_req=0; pc_in=0x24 -> 0x20 is popped and 0x28 is requested.
REQ-036 Boundaries: pc_in=0x102 -> misalign=1, inst_valid=0, no request; prefetch from 0xFFFFFFFC -> next mem_addr=0x00000000.
REQ-037 Reset mid-transfer: reset=0 while mem_req=1 -> mem_req=0 at once; mem_ack arriving after reset release while IDLE causes no buffer write.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction prefetch buffer between the CPU fetch port and
// instruction memory. A small FIFO of {addr, data} words is kept ahead of
// pc_in. At most one memory read is outstanding. Buffer entry 0 is the head.
//
// Memory handshake: mem_req/mem_addr are raised by this block and held
// stable until the edge where mem_req=1 and mem_ack=1 are both sampled.
// That edge completes the transfer, and mem_rdata is valid only in that
// cycle. mem_ack while mem_req=0 is ignored. A new request may follow in
// the very next cycle.
//
// fsm_state exposes the request FSM: 0=IDLE, 1=BUSY, 2=DROP.
module inst_fetch #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic        misalign,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  fsm_state
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [31:0]   req_addr, req_addr_nxt;
    logic [CW-1:0] cnt, cnt_pop, cnt_nxt, pop, hit_idx;
    logic [31:0]   buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [31:0]   nxt_addr [DEPTH];
    logic [31:0]   nxt_data [DEPTH];
    logic          hit, busy_match, bypass, redirect, flush, fill, complete;
    logic [31:0]   hit_data, last_addr;

    assign misalign   = |pc_in[1:0];
    assign complete   = (state != ST_IDLE) && mem_ack;
    assign busy_match = (state == ST_BUSY) && (req_addr == pc_in);
    // The returning word for pc_in is handed straight to the CPU.
    assign bypass     = !misalign && !hit && busy_match && mem_ack;
    // Nothing buffered or in flight serves pc_in: the stream is abandoned.
    assign redirect   = !misalign && !hit && !busy_match;
    assign flush      = misalign || redirect;
    assign fill       = (state == ST_BUSY) && mem_ack && !flush;
    // A bypass behaves like a hit on the word being filled, so every older
    // entry is stale and popped.
    assign pop        = hit ? hit_idx : (bypass ? cnt : '0);
    assign cnt_pop    = cnt - pop;
    assign cnt_nxt    = flush ? '0 : (cnt_pop + {{(CW-1){1'b0}}, fill});

    assign inst_valid  = hit || bypass;
    assign instruction = hit ? hit_data : (bypass ? mem_rdata : NOP_WORD);
    assign mem_req     = (state != ST_IDLE);
    assign mem_addr    = req_addr;
    assign fsm_state   = state;

    // Lookup of pc_in in the valid entries (lowest index wins) and the tail address.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        hit_data  = NOP_WORD;
        last_addr = buf_addr[0];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < cnt && buf_addr[i] == pc_in && !misalign) begin
                hit      = 1'b1;
                hit_idx  = CW'(i);
                hit_data = buf_data[i];
            end
            if (CW'(i + 1) == cnt) begin
                last_addr = buf_addr[i];
            end
        end
    end

    // Next buffer contents: shift out popped entries, then append the fill word.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt_addr[i] = buf_addr[i];
            nxt_data[i] = buf_data[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j == i + int'(pop)) begin
                    nxt_addr[i] = buf_addr[j];
                    nxt_data[i] = buf_data[j];
                end
            end
            if (fill && CW'(i) == cnt_pop) begin
                nxt_addr[i] = req_addr;
                nxt_data[i] = mem_rdata;
            end
        end
    end

    // Request FSM: redirect, drop and sequential prefetch decisions.
    always_comb begin
        state_nxt    = state;
        req_addr_nxt = req_addr;
        if (misalign) begin
            // No new fetch; an in-flight read finishes and is thrown away.
            if (complete) begin
                state_nxt = ST_IDLE;
            end
        end else if (redirect) begin
            if (state == ST_IDLE || complete) begin
                state_nxt    = ST_BUSY;
                req_addr_nxt = pc_in;
            end else begin
                state_nxt = ST_DROP;
            end
        end else if (state == ST_IDLE) begin
            // Hit while idle: top up the buffer behind the last entry.
            if (cnt_pop < FULL) begin
                state_nxt    = ST_BUSY;
                req_addr_nxt = last_addr + 32'd4;
            end
        end else if (complete) begin
            // BUSY completion that is kept: chain the next sequential word.
            if (cnt_nxt < FULL) begin
                state_nxt    = ST_BUSY;
                req_addr_nxt = req_addr + 32'd4;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // FSM and request address registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            req_addr <= '0;
        end else begin
            state    <= state_nxt;
            req_addr <= req_addr_nxt;
        end
    end

    // Buffer storage and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_addr[i] <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            cnt <= cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                buf_addr[i] <= nxt_addr[i];
                buf_data[i] <= nxt_data[i];
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized bench for inst_fetch with a queue-based model
// of the prefetch buffer, a latency-programmable memory responder and a
// simple CPU that advances pc_in whenever a word is delivered.
module tb_inst_fetch;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        misalign;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  fsm_state;

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    inst_fetch #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_in       (pc_in),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .misalign    (misalign),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .fsm_state   (fsm_state)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic        m_pend, m_drop;
    logic [31:0] m_paddr;
    logic        m_valid, m_mis, m_match, m_done;
    logic [31:0] m_instr;
    int          m_k;
    logic [31:0] exp_q [$];

    // memory responder and CPU knobs
    int mem_wait;
    int lat_min, lat_max;
    bit spur_en;
    int mis_hold;
    logic obs_valid, obs_req;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) + 32'h01234567;
    endfunction

    function automatic logic [31:0] exp_state();
        if (!m_pend) return 32'd0;
        return m_drop ? 32'd2 : 32'd1;
    endfunction

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        exp_q.delete();
        m_pend   = 1'b0;
        m_drop   = 1'b0;
        m_paddr  = '0;
        mem_wait = 0;
    endtask

    task automatic model_issue(input logic [31:0] a);
        m_pend   = 1'b1;
        m_drop   = 1'b0;
        m_paddr  = a;
        mem_wait = int'($urandom_range(lat_max, lat_min));
    endtask

    // What the CPU should see this cycle, from the current inputs.
    task automatic model_eval();
        m_mis = (pc_in[1:0] != 2'b00);
        m_k   = -1;
        if (!m_mis) begin
            for (int i = q_addr.size() - 1; i >= 0; i--) begin
                if (q_addr[i] == pc_in) m_k = i;
            end
        end
        m_match = m_pend && !m_drop && (m_paddr == pc_in);
        m_done  = m_pend && mem_ack;
        m_valid = 1'b0;
        m_instr = NOP_WORD;
        if (m_k >= 0) begin
            m_valid = 1'b1;
            m_instr = q_data[m_k];
        end else if (!m_mis && m_match && mem_ack) begin
            m_valid = 1'b1;
            m_instr = mem_rdata;
        end
        if (m_valid) exp_q.push_back(memword(pc_in));
    endtask

    // Buffer/request update at the clock edge.
    task automatic model_step();
        if (m_mis) begin
            q_addr.delete();
            q_data.delete();
            if (m_done) begin
                m_pend = 1'b0;
                m_drop = 1'b0;
            end
        end else if (m_k >= 0 || m_match) begin
            if (m_k >= 0) begin
                repeat (m_k) begin
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                end
            end else if (m_done) begin
                q_addr.delete();
                q_data.delete();
            end
            if (m_done) begin
                q_addr.push_back(m_paddr);
                q_data.push_back(mem_rdata);
                m_pend = 1'b0;
            end
            if (!m_pend && q_addr.size() < DEPTH) model_issue(q_addr[$] + 32'd4);
        end else begin
            q_addr.delete();
            q_data.delete();
            if (!m_pend || m_done) model_issue(pc_in);
            else m_drop = 1'b1;
        end
    endtask

    // driver: memory responder for the coming cycle
    task automatic drive_mem();
        if (m_pend) begin
            if (mem_wait == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = memword(m_paddr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                mem_wait--;
            end
        end else begin
            mem_ack   = spur_en && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    endtask

    // One cycle: predict, compare at the falling edge, advance the model.
    task automatic tick();
        logic [31:0] e;
        model_eval();
        @(negedge clock);
        obs_valid = inst_valid;
        obs_req   = mem_req;
        check_eq("inst_valid", 32'(inst_valid), 32'(m_valid));
        check_eq("instruction", instruction, m_instr);
        check_eq("misalign", 32'(misalign), 32'(m_mis));
        check_eq("mem_req", 32'(mem_req), 32'(m_pend));
        if (m_pend) check_eq("mem_addr", mem_addr, m_paddr);
        check_eq("fsm_state", 32'(fsm_state), exp_state());
        if (inst_valid) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("deliver", instruction, e);
            end else begin
                check_eq("deliver_extra", 32'(inst_valid), 32'd0);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end
        @(posedge clock);
        model_step();
        #1;
        drive_mem();
    endtask

    task automatic do_reset(input logic [31:0] pc);
        @(posedge clock);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        pc_in = pc;
        drive_mem();
    endtask

    // driver: CPU pc policy for the random phase
    task automatic cpu_next();
        int r;
        if (mis_hold > 0) begin
            mis_hold--;
            if (mis_hold == 0) pc_in = 32'h100 + 32'($urandom_range(0, 63)) * 32'd4;
            return;
        end
        if (!m_valid) return;
        r = int'($urandom_range(0, 99));
        if (r < 70)      pc_in = pc_in + 32'd4;
        else if (r < 78) pc_in = pc_in + 32'd8;
        else if (r < 86) pc_in = pc_in - 32'($urandom_range(1, 2)) * 32'd4;
        else if (r < 95) pc_in = 32'h100 + 32'($urandom_range(0, 63)) * 32'd4;
        else begin
            pc_in    = pc_in | 32'($urandom_range(1, 3));
            mis_hold = 3;
        end
    endtask

    initial begin
        int n;
        bit seen;
        reset     = 1'b0;
        pc_in     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        lat_min   = 0;
        lat_max   = 0;
        spur_en   = 1'b0;
        mis_hold  = 0;
        model_reset();

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_instruction", instruction, NOP_WORD);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_fsm", 32'(fsm_state), 32'd0);

        // cold start, latency 2
        lat_min = 2;
        lat_max = 2;
        @(posedge clock);
        #1;
        reset = 1'b1;
        pc_in = 32'h0;
        drive_mem();
        tick();
        check_eq("cold_req", 32'(mem_req), 32'd1);
        check_eq("cold_addr", mem_addr, 32'h0);
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            n++;
            seen = obs_valid;
        end
        check_eq("cold_valid_seen", 32'(seen), 32'd1);
        check_eq("cold_latency", 32'(n), 32'd3);
        check_eq("cold_next_req", 32'(mem_req), 32'd1);
        check_eq("cold_next_addr", mem_addr, 32'h4);

        // sequential stream, zero-wait memory
        lat_min = 0;
        lat_max = 0;
        do_reset(32'h100);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i >= 5 && obs_valid) n++;
            if (m_valid) pc_in = pc_in + 32'd4;
        end
        check_eq("stream_valid_count", 32'(n), 32'd35);

        // full buffer
        do_reset(32'h20);
        repeat (6) tick();
        check_eq("full_mem_req", 32'(mem_req), 32'd0);
        pc_in = 32'h24;
        tick();
        check_eq("full_hit24", 32'(obs_valid), 32'd1);
        check_eq("full_no_fetch", 32'(obs_req), 32'd0);
        check_eq("full_req28", 32'(mem_req), 32'd1);
        check_eq("full_addr28", mem_addr, 32'h28);
        pc_in = 32'h20;
        tick();
        check_eq("full_popped20", 32'(obs_valid), 32'd0);

        // redirect while 0x108 is in flight
        lat_min = 3;
        lat_max = 3;
        do_reset(32'h100);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = obs_valid;
        end
        pc_in = 32'h104;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = obs_valid;
        end
        check_eq("red_104_seen", 32'(seen), 32'd1);
        tick();
        check_eq("red_req_108", 32'(mem_req), 32'd1);
        check_eq("red_addr_108", mem_addr, 32'h108);
        pc_in = 32'h400;
        tick();
        check_eq("red_drop", 32'(fsm_state), 32'd2);
        for (int i = 0; i < 20; i++) begin
            if (mem_req && mem_addr == 32'h400) break;
            tick();
            check_eq("red_no_deliver", 32'(obs_valid), 32'd0);
        end
        check_eq("red_reissue", mem_addr, 32'h400);
        check_eq("red_reissue_busy", 32'(fsm_state), 32'd1);

        // misaligned pc
        lat_min = 1;
        lat_max = 1;
        pc_in = 32'h102;
        repeat (8) tick();
        check_eq("mis_flag", 32'(misalign), 32'd1);
        check_eq("mis_valid", 32'(inst_valid), 32'd0);
        check_eq("mis_no_req", 32'(mem_req), 32'd0);

        // prefetch wraps past the top of the address space
        pc_in = 32'hFFFFFFFC;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = obs_valid;
        end
        check_eq("wrap_seen", 32'(seen), 32'd1);
        check_eq("wrap_req", 32'(mem_req), 32'd1);
        check_eq("wrap_addr", mem_addr, 32'h0);

        // randomized traffic
        lat_min = 0;
        lat_max = 3;
        spur_en = 1'b1;
        do_reset(32'h100);
        for (int i = 0; i < 1500; i++) begin
            tick();
            cpu_next();
        end

        // reset in the middle of a transfer
        spur_en = 1'b0;
        lat_min = 3;
        lat_max = 3;
        do_reset(32'h300);
        tick();
        #3;
        reset = 1'b0;
        #1;
        check_eq("midrst_req", 32'(mem_req), 32'd0);
        check_eq("midrst_addr", mem_addr, 32'd0);
        check_eq("midrst_valid", 32'(inst_valid), 32'd0);
        check_eq("midrst_instr", instruction, NOP_WORD);
        check_eq("midrst_fsm", 32'(fsm_state), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset     = 1'b1;
        pc_in     = 32'h300;
        mem_ack   = 1'b1;
        mem_rdata = memword(32'h300);
        tick();
        check_eq("midrst_ack_ignored", 32'(obs_valid), 32'd0);
        check_eq("midrst_new_req", 32'(mem_req), 32'd1);
        check_eq("midrst_new_addr", mem_addr, 32'h300);
        tick();
        check_eq("midrst_no_write", 32'(obs_valid), 32'd0);
        repeat (6) tick();

        check_eq("sb_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
